// File: rtl/pc_sequencer_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
// Next-PC source encoding and the STEP alignment mask.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_HOLD,
    SRC_RET,
    SRC_JUMP,
    SRC_BRANCH,
    SRC_SEQ
  } pc_src_e;

  // Keeps the bits above log2(step) and clears the bits below it.
  function automatic logic [63:0] align_mask(input int unsigned step);
    return ~(64'(step) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Redirect request and PC result bundle between fetch control and pc_sequencer.
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                Stall;
  logic                BranchTaken;
  logic [PC_WIDTH-1:0] BranchTarget;
  logic                Jump;
  logic                Call;
  logic [PC_WIDTH-1:0] JumpTarget;
  logic                Ret;
  logic [PC_WIDTH-1:0] RetTarget;
  logic [PC_WIDTH-1:0] PC;
  logic [PC_WIDTH-1:0] PCPlusStep;
  logic                MisalignErr;
  logic                RasUnderflow;
  logic                RasFull;

  modport master (
    output Stall, BranchTaken, BranchTarget, Jump, Call, JumpTarget, Ret, RetTarget,
    input  PC, PCPlusStep, MisalignErr, RasUnderflow, RasFull
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, Jump, Call, JumpTarget, Ret, RetTarget,
    output PC, PCPlusStep, MisalignErr, RasUnderflow, RasFull
  );
endinterface

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module pc_ras #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    top_idx;
  logic [AW:0]      cnt;

  assign top_idx = wp - AW'(1);
  assign top     = mem[top_idx];
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (pop && !empty) begin
      wp  <= top_idx;
      cnt <= cnt - (AW+1)'(1);
    end else if (push) begin
      wp <= wp + AW'(1);
      if (!full) cnt <= cnt + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) mem[wp] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with fixed-priority redirects and sequential step.
// Define PC_SEQ_RAS_EN to build in the return-address stack predictor.
//
// src        | meaning
// SRC_RESET  | load RESET_VECTOR
// SRC_HOLD   | stall: PC and stack hold
// SRC_RET    | return: stack top, or RetTarget when empty / no stack
// SRC_JUMP   | jump or call to JumpTarget (call also pushes)
// SRC_BRANCH | taken branch to BranchTarget
// SRC_SEQ    | PC + STEP
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    PC_WIDTH     = 32,
  parameter int unsigned           STEP         = 4,
  parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
  parameter int                    RAS_DEPTH    = 4
) (
  input logic           Clk,
  input logic           Reset,
  pc_sequencer_if.slave bus
);
  localparam logic [PC_WIDTH-1:0] MASK   = PC_WIDTH'(align_mask(STEP));
  localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("pc_sequencer: RAS_DEPTH must be a power of two >= 2");
  end

  pc_src_e             src;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_plus;
  logic [PC_WIDTH-1:0] ret_val;
  logic [PC_WIDTH-1:0] raw;
  logic                redirect;
  logic                misalign_q;

  assign pc_plus         = pc_q + STEP_W;
  assign bus.PC          = pc_q;
  assign bus.PCPlusStep  = pc_plus;
  assign bus.MisalignErr = misalign_q;

  always_comb begin
    src = SRC_SEQ;
    if (Reset)                      src = SRC_RESET;
    else if (bus.Stall)             src = SRC_HOLD;
    else if (bus.Ret)               src = SRC_RET;
    else if (bus.Jump || bus.Call)  src = SRC_JUMP;
    else if (bus.BranchTaken)       src = SRC_BRANCH;
  end

  always_comb begin
    raw = '0;
    case (src)
      SRC_RET:    raw = ret_val;
      SRC_JUMP:   raw = bus.JumpTarget;
      SRC_BRANCH: raw = bus.BranchTarget;
      default:    raw = '0;
    endcase
  end

  assign redirect = (src == SRC_RET) || (src == SRC_JUMP) || (src == SRC_BRANCH);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      case (src)
        SRC_HOLD: pc_q <= pc_q;
        SRC_SEQ:  pc_q <= pc_plus;
        default:  pc_q <= raw & MASK;
      endcase
      misalign_q <= redirect && (|(raw & ~MASK));
    end
  end

`ifdef PC_SEQ_RAS_EN
  logic                ras_empty;
  logic                ras_full;
  logic                ras_push;
  logic                ras_pop;
  logic [PC_WIDTH-1:0] ras_top;
  logic                underflow_q;

  // Ret outranks Call, so a simultaneous pair only pops.
  assign ras_push = (src == SRC_JUMP) && bus.Call;
  assign ras_pop  = (src == SRC_RET) && !ras_empty;
  assign ret_val  = ras_empty ? bus.RetTarget : ras_top;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_ras (
    .clk   (Clk),
    .rst   (Reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .din   (pc_plus),
    .top   (ras_top),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_ff @(posedge Clk) begin
    if (Reset) underflow_q <= 1'b0;
    else       underflow_q <= (src == SRC_RET) && ras_empty;
  end

  assign bus.RasUnderflow = underflow_q;
  assign bus.RasFull      = ras_full;
`else
  assign ret_val          = bus.RetTarget;
  assign bus.RasUnderflow = 1'b0;
  assign bus.RasFull      = 1'b0;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; RAS steps are included when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;
`ifdef PC_SEQ_RAS_EN
  localparam logic RAS = 1'b1;
`else
  localparam logic RAS = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  pc_sequencer_if #(.PC_WIDTH(32)) bus ();

  pc_sequencer #(
    .PC_WIDTH     (32),
    .STEP         (4),
    .RESET_VECTOR (32'h0),
    .RAS_DEPTH    (4)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset            = 1'b1;
    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = '0;
    bus.Jump         = 1'b0;
    bus.Call         = 1'b0;
    bus.JumpTarget   = '0;
    bus.Ret          = 1'b0;
    bus.RetTarget    = '0;

    cyc();
    chk("rst_pc", bus.PC, 32'h0);
    chk("rst_pcplus", bus.PCPlusStep, 32'h4);
    chk("rst_misalign", 32'(bus.MisalignErr), 32'h0);
    chk("rst_underflow", 32'(bus.RasUnderflow), 32'h0);
    chk("rst_full", 32'(bus.RasFull), 32'h0);
    Reset = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("seq_pc", bus.PC, 32'(4 * i));
      chk("seq_pcplus", bus.PCPlusStep, 32'(4 * i + 4));
    end

    bus.Jump = 1'b1; bus.JumpTarget = 32'hFFFF_FFFC;
    cyc();
    chk("jump_top_pc", bus.PC, 32'hFFFF_FFFC);
    bus.Jump = 1'b0;
    cyc();
    chk("wrap_pc", bus.PC, 32'h0);
    chk("wrap_misalign", 32'(bus.MisalignErr), 32'h0);

    bus.BranchTaken = 1'b1; bus.BranchTarget = 32'h100;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h200;
    cyc();
    chk("jump_over_branch", bus.PC, 32'h200);
    bus.Stall = 1'b1;
    cyc();
    chk("stall_hold", bus.PC, 32'h200);
    bus.Jump = 1'b0; bus.BranchTarget = 32'h103;
    cyc();
    chk("stall_hold2", bus.PC, 32'h200);
    chk("stall_no_misalign", 32'(bus.MisalignErr), 32'h0);
    bus.Stall = 1'b0;
    cyc();
    chk("branch_aligned_pc", bus.PC, 32'h100);
    chk("branch_misalign", 32'(bus.MisalignErr), 32'h1);
    bus.BranchTaken = 1'b0;
    cyc();
    chk("after_branch_pc", bus.PC, 32'h104);
    chk("misalign_pulse_end", 32'(bus.MisalignErr), 32'h0);

    bus.Ret = 1'b1; bus.RetTarget = 32'h300;
    bus.Jump = 1'b1; bus.JumpTarget = 32'h200; bus.BranchTaken = 1'b1;
    cyc();
    chk("ret_over_jump", bus.PC, 32'h300);
    chk("ret_empty_underflow", 32'(bus.RasUnderflow), 32'(RAS));
    bus.Ret = 1'b0; bus.Jump = 1'b0; bus.BranchTaken = 1'b0;
    cyc();
    chk("underflow_pulse_end", 32'(bus.RasUnderflow), 32'h0);

`ifdef PC_SEQ_RAS_EN
    bus.Jump = 1'b1; bus.JumpTarget = 32'h10;
    cyc();
    chk("ras_start_pc", bus.PC, 32'h10);
    bus.Jump = 1'b0; bus.Call = 1'b1;
    bus.JumpTarget = 32'h20; cyc(); chk("call1_pc", bus.PC, 32'h20);
    bus.JumpTarget = 32'h30; cyc(); chk("call2_pc", bus.PC, 32'h30);
    chk("not_full_yet", 32'(bus.RasFull), 32'h0);
    bus.Jump = 1'b1;
    bus.JumpTarget = 32'h40; cyc(); chk("call3_pc", bus.PC, 32'h40);
    bus.Jump = 1'b0;
    bus.JumpTarget = 32'h50; cyc(); chk("call4_pc", bus.PC, 32'h50);
    chk("full_after4", 32'(bus.RasFull), 32'h1);
    bus.JumpTarget = 32'h60; cyc(); chk("call5_pc", bus.PC, 32'h60);
    chk("full_after5", 32'(bus.RasFull), 32'h1);
    bus.Call = 1'b0;

    bus.Ret = 1'b1; bus.RetTarget = 32'h700;
    cyc(); chk("ret1_pc", bus.PC, 32'h54);
    chk("full_after_pop", 32'(bus.RasFull), 32'h0);
    cyc(); chk("ret2_pc", bus.PC, 32'h44);
    cyc(); chk("ret3_pc", bus.PC, 32'h34);
    cyc(); chk("ret4_pc", bus.PC, 32'h24);
    chk("ret4_no_underflow", 32'(bus.RasUnderflow), 32'h0);
    bus.RetTarget = 32'h80;
    cyc(); chk("ret5_pc", bus.PC, 32'h80);
    chk("ret5_underflow", 32'(bus.RasUnderflow), 32'h1);
    bus.Ret = 1'b0;
    cyc(); chk("post_ret_pc", bus.PC, 32'h84);
    chk("underflow_clear", 32'(bus.RasUnderflow), 32'h0);

    bus.Jump = 1'b1; bus.JumpTarget = 32'h30;
    cyc();
    bus.Jump = 1'b0; bus.Call = 1'b1; bus.JumpTarget = 32'h40;
    cyc();
    bus.JumpTarget = 32'h50;
    cyc();
    chk("cr_setup_pc", bus.PC, 32'h50);
    bus.Ret = 1'b1; bus.JumpTarget = 32'h600; bus.RetTarget = 32'h700;
    cyc(); chk("call_ret_pc", bus.PC, 32'h44);
    bus.Call = 1'b0;
    cyc(); chk("cr_next_pop", bus.PC, 32'h34);
    chk("cr_no_underflow", 32'(bus.RasUnderflow), 32'h0);
    cyc(); chk("cr_empty_pc", bus.PC, 32'h700);
    chk("cr_empty_underflow", 32'(bus.RasUnderflow), 32'h1);
    bus.Ret = 1'b0;

    bus.Call = 1'b1; bus.JumpTarget = 32'h200;
    cyc();
    bus.JumpTarget = 32'h300;
    cyc();
    bus.Call = 1'b0;
    Reset = 1'b1; bus.Ret = 1'b1; bus.RetTarget = 32'h88;
    cyc(); chk("midrst_pc", bus.PC, 32'h0);
    chk("midrst_underflow", 32'(bus.RasUnderflow), 32'h0);
    Reset = 1'b0;
    cyc(); chk("post_rst_ret_pc", bus.PC, 32'h88);
    chk("post_rst_underflow", 32'(bus.RasUnderflow), 32'h1);
    bus.Ret = 1'b0;
`else
    bus.Call = 1'b1; bus.JumpTarget = 32'h40;
    cyc();
    chk("call_norас_pc", bus.PC, 32'h40);
    chk("call_no_full", 32'(bus.RasFull), 32'h0);
    bus.Call = 1'b0; bus.Ret = 1'b1; bus.RetTarget = 32'h82;
    cyc();
    chk("ret_target_pc", bus.PC, 32'h80);
    chk("ret_misalign", 32'(bus.MisalignErr), 32'h1);
    chk("ret_no_underflow", 32'(bus.RasUnderflow), 32'h0);
    bus.Ret = 1'b0;
    Reset = 1'b1;
    cyc();
    chk("midrst_pc", bus.PC, 32'h0);
    chk("midrst_misalign", 32'(bus.MisalignErr), 32'h0);
    Reset = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
